// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared types and font constants for the seven-segment scan scheduler
// Contents: SEG_BLANK, SEG_FONT (active-high {g,f,e,d,c,b,a} per hex value),
//           digit_t entry {blank, dp, hex}, DIGIT_BLANK reset entry, state_t {OPEN, PENDING}.
package seg_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Entry n is the glyph for hex value n; bit 0 = segment a.
    localparam logic [15:0][6:0] SEG_FONT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef struct packed {
        logic       blank;
        logic       dp;
        logic [3:0] hex;
    } digit_t;

    localparam digit_t DIGIT_BLANK = '{blank: 1'b1, dp: 1'b0, hex: 4'h0};

    typedef enum logic {
        OPEN    = 1'b0,
        PENDING = 1'b1
    } state_t;

endpackage

// File: rtl/hex_to_seg.sv
// rtl/hex_to_seg.sv - combinational hex + dp to active-low segment pattern
// Ports: hex[3:0] value 0..F, dp decimal point on, smg[7:0] {dp,g,f,e,d,c,b,a} active-low.
module hex_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] hex,
    input  logic       dp,
    output logic [7:0] smg
);

    assign smg = ~{dp, SEG_FONT[hex]};

endmodule

// File: rtl/seg_scan_sched.sv
// rtl/seg_scan_sched.sv - 4-digit seven-segment scan scheduler with tear-free shadow/active buffers
// Ports: clk, rst (async active-high); wr_valid/wr_ready/wr_addr/wr_hex/wr_dp/wr_blank shadow
//        write port; commit swap request; brightness[2:0] duty; dig[3:0], smg[7:0] active-low
//        display drive; frame_done pulse in the last cycle of the digit-3 slot.
// Optional: LEADING_ZERO_BLANK_EN darkens leading zeros (digit 0 always shown).
module seg_scan_sched
    import seg_pkg::*;
#(
    parameter int DIGIT_TICKS = 27000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [1:0] wr_addr,
    input  logic [3:0] wr_hex,
    input  logic       wr_dp,
    input  logic       wr_blank,
    input  logic       commit,
    input  logic [2:0] brightness,
    output logic [3:0] dig,
    output logic [7:0] smg,
    output logic       frame_done
);

    localparam int SUB_TICKS = DIGIT_TICKS / 8;
    localparam int TW = $clog2(DIGIT_TICKS);
    localparam int SW = $clog2(SUB_TICKS);
    localparam logic [TW-1:0] TICK_LAST = TW'(DIGIT_TICKS - 1);
    localparam logic [SW-1:0] SUB_LAST  = SW'(SUB_TICKS - 1);

    state_t            state;
    digit_t [3:0]      shadow;
    digit_t [3:0]      active;
    logic   [TW-1:0]   tick_cnt;
    logic   [SW-1:0]   sub_cnt;
    logic   [2:0]      sub;
    logic   [1:0]      idx;
    logic   [3:0]      eff_blank;
    logic   [7:0]      seg_lo;
    logic              frame_end;
    logic              lit;

    assign frame_end  = (tick_cnt == TICK_LAST) && (idx == 2'd3);
    assign frame_done = frame_end;
    assign wr_ready   = (state == OPEN);

`ifdef LEADING_ZERO_BLANK_EN
    logic higher_dark;
`endif

    // Per-digit darkness after optional leading-zero suppression.
    always_comb begin
        eff_blank = '0;
`ifdef LEADING_ZERO_BLANK_EN
        higher_dark = 1'b1;
        for (int i = 3; i >= 1; i--) begin
            eff_blank[i] = active[i].blank |
                           ((active[i].hex == 4'h0) && !active[i].dp && higher_dark);
            higher_dark  = higher_dark & eff_blank[i];
        end
        eff_blank[0] = active[0].blank;
`else
        for (int i = 0; i < 4; i++) begin
            eff_blank[i] = active[i].blank;
        end
`endif
    end

    hex_to_seg u_dec (
        .hex (active[idx].hex),
        .dp  (active[idx].dp),
        .smg (seg_lo)
    );

    // Tick 0 of every slot is dead time so the previous digit's segments cannot ghost.
    assign lit = (tick_cnt != '0) && (sub <= brightness) && !eff_blank[idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= OPEN;
            shadow   <= {4{DIGIT_BLANK}};
            active   <= {4{DIGIT_BLANK}};
            tick_cnt <= '0;
            sub_cnt  <= '0;
            sub      <= '0;
            idx      <= '0;
            dig      <= 4'b1111;
            smg      <= SEG_BLANK;
        end else begin
            // sub tracks tick_cnt / SUB_TICKS without a divider.
            if (tick_cnt == TICK_LAST) begin
                tick_cnt <= '0;
                sub_cnt  <= '0;
                sub      <= '0;
                idx      <= idx + 2'd1;
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
                if (sub_cnt == SUB_LAST) begin
                    sub_cnt <= '0;
                    sub     <= sub + 3'd1;
                end else begin
                    sub_cnt <= sub_cnt + 1'b1;
                end
            end

            if (wr_valid && wr_ready) begin
                shadow[wr_addr] <= '{blank: wr_blank, dp: wr_dp, hex: wr_hex};
            end

            // Shadow is frozen while PENDING, so the swap copies exactly what was committed.
            case (state)
                OPEN: begin
                    if (commit) begin
                        state <= PENDING;
                    end
                end
                PENDING: begin
                    if (frame_end) begin
                        active <= shadow;
                        state  <= OPEN;
                    end
                end
                default: state <= OPEN;
            endcase

            if (lit) begin
                dig <= ~(4'b0001 << idx);
                smg <= seg_lo;
            end else begin
                dig <= 4'b1111;
                smg <= SEG_BLANK;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_sched.sv
// tb/tb_seg_scan_sched.sv - randomized scoreboard bench for seg_scan_sched
module tb_seg_scan_sched;

    localparam int DT = 16;

    logic       clk;
    logic       rst;
    logic       wr_valid;
    logic       wr_ready;
    logic [1:0] wr_addr;
    logic [3:0] wr_hex;
    logic       wr_dp;
    logic       wr_blank;
    logic       commit;
    logic [2:0] brightness;
    logic [3:0] dig;
    logic [7:0] smg;
    logic       frame_done;

    seg_scan_sched #(.DIGIT_TICKS(DT)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_hex     (wr_hex),
        .wr_dp      (wr_dp),
        .wr_blank   (wr_blank),
        .commit     (commit),
        .brightness (brightness),
        .dig        (dig),
        .smg        (smg),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Common-anode glyphs, active-low {dp,g,f,e,d,c,b,a}, dp off.
    localparam logic [7:0] FONT_LO [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    typedef struct packed {
        logic [3:0] dig;
        logic [7:0] smg;
        logic       fd;
        logic       rdy;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: display state described by cycle number since reset.
    int         t;
    bit         pending;
    bit         s_blank [4];
    bit         s_dp    [4];
    logic [3:0] s_hex   [4];
    bit         a_blank [4];
    bit         a_dp    [4];
    logic [3:0] a_hex   [4];

    task automatic model_reset();
        t = 0;
        pending = 0;
        for (int i = 0; i < 4; i++) begin
            s_blank[i] = 1; s_dp[i] = 0; s_hex[i] = 4'h0;
            a_blank[i] = 1; a_dp[i] = 0; a_hex[i] = 4'h0;
        end
    endtask

    function automatic bit is_zero(int i);
        return (a_hex[i] == 4'h0) && !a_dp[i];
    endfunction

    function automatic bit dark(int i);
        if (a_blank[i]) return 1;
`ifdef LEADING_ZERO_BLANK_EN
        if (i == 0 || !is_zero(i)) return 0;
        for (int j = i + 1; j < 4; j++) begin
            if (!(a_blank[j] || is_zero(j))) return 0;
        end
        return 1;
`else
        return 0;
`endif
    endfunction

    // Predict the outputs visible after the coming edge, then advance the model.
    task automatic model_edge();
        int   tick, slot, tick2, slot2;
        bit   lit;
        exp_t e;
        tick = t % DT;
        slot = (t / DT) % 4;
        lit  = (tick != 0) && ((tick / (DT / 8)) <= int'(brightness)) && !dark(slot);
        e.dig = 4'hF;
        e.smg = 8'hFF;
        if (lit) begin
            e.dig[slot] = 1'b0;
            e.smg = FONT_LO[a_hex[slot]];
            if (a_dp[slot]) e.smg[7] = 1'b0;
        end
        if (wr_valid && !pending) begin
            s_blank[wr_addr] = wr_blank;
            s_dp[wr_addr]    = wr_dp;
            s_hex[wr_addr]   = wr_hex;
        end
        if (!pending) begin
            if (commit) pending = 1;
        end else if (tick == DT - 1 && slot == 3) begin
            for (int i = 0; i < 4; i++) begin
                a_blank[i] = s_blank[i]; a_dp[i] = s_dp[i]; a_hex[i] = s_hex[i];
            end
            pending = 0;
        end
        t++;
        tick2 = t % DT;
        slot2 = (t / DT) % 4;
        e.fd  = (tick2 == DT - 1) && (slot2 == 3);
        e.rdy = !pending;
        q.push_back(e);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_underflow at %0t: no expected entry", $time);
            end else begin
                e = q.pop_front();
                if ({dig, smg, frame_done, wr_ready} !== e) begin
                    failures++;
                    $display("FAIL display at %0t: got dig=%b smg=%h fd=%b rdy=%b want dig=%b smg=%h fd=%b rdy=%b",
                             $time, dig, smg, frame_done, wr_ready, e.dig, e.smg, e.fd, e.rdy);
                end
            end
        end
    end

    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_now(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Asynchronous reset asserted between edges; outputs must react before any clock.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        check_now("reset_dig", {4'h0, dig}, 8'h0F);
        check_now("reset_smg", smg, 8'hFF);
        check_now("reset_wr_ready", {7'h0, wr_ready}, 8'h01);
        check_now("reset_frame_done", {7'h0, frame_done}, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        q.delete();
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!wr_ready && n < 300) begin step(); n++; end
        checks++;
        if (!wr_ready) begin
            failures++;
            $display("FAIL wait_ready: wr_ready=%b after %0d cycles want 1", wr_ready, n);
        end
    endtask

    // Holds wr_valid until a transfer edge, as a master must while PENDING.
    task automatic do_write(input logic [1:0] a, input logic [3:0] h, input logic d, input logic b);
        bit acc = 0;
        int n = 0;
        wr_valid = 1'b1; wr_addr = a; wr_hex = h; wr_dp = d; wr_blank = b;
        while (!acc && n < 300) begin
            acc = wr_ready;
            step();
            n++;
        end
        wr_valid = 1'b0;
        checks++;
        if (!acc) begin
            failures++;
            $display("FAIL write_accept: accepted=%b after %0d cycles want 1", acc, n);
        end
    endtask

    task automatic commit_pulse();
        commit = 1'b1;
        step();
        commit = 1'b0;
    endtask

    initial begin
        bit acc;
        rst = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_hex = '0; wr_dp = 1'b0;
        wr_blank = 1'b0; commit = 1'b0; brightness = 3'd7;
        model_reset();
        do_reset();
        idle(70);

        // Write 3,2,1,0 and commit; swap happens at the next boundary.
        do_write(2'd0, 4'h3, 1'b0, 1'b0);
        do_write(2'd1, 4'h2, 1'b0, 1'b0);
        do_write(2'd2, 4'h1, 1'b0, 1'b0);
        do_write(2'd3, 4'h0, 1'b0, 1'b0);
        commit_pulse();
        idle(140);

        // Write and commit in the same cycle.
        wait_ready();
        wr_valid = 1'b1; wr_addr = 2'd2; wr_hex = 4'hE; wr_dp = 1'b0; wr_blank = 1'b0;
        commit = 1'b1;
        step();
        wr_valid = 1'b0; commit = 1'b0;
        idle(140);

        // Write held while PENDING; visible only after a second commit.
        wait_ready();
        commit_pulse();
        do_write(2'd0, 4'hF, 1'b0, 1'b0);
        idle(70);
        commit_pulse();
        idle(140);

        // Brightness extremes.
        brightness = 3'd1; idle(70);
        brightness = 3'd0; idle(70);
        brightness = 3'd7;

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            if (!wr_valid && $urandom_range(3) == 0) begin
                wr_valid = 1'b1;
                wr_addr  = 2'($urandom_range(3));
                wr_hex   = 4'($urandom_range(15));
                wr_dp    = ($urandom_range(3) == 0);
                wr_blank = ($urandom_range(7) == 0);
            end
            commit = ($urandom_range(39) == 0);
            if ($urandom_range(49) == 0) brightness = 3'($urandom_range(7));
            acc = wr_valid && wr_ready;
            step();
            if (acc) wr_valid = 1'b0;
            commit = 1'b0;
        end
        wr_valid = 1'b0;
        brightness = 3'd7;

        // Reset while PENDING discards the commit and the shadow contents.
        wait_ready();
        do_write(2'd1, 4'h5, 1'b0, 1'b0);
        commit_pulse();
        idle(5 + $urandom_range(20));
        do_reset();
        commit_pulse();
        idle(140);

        // 0,0,4,2 on addr3..0 (leading zeros dark when suppression is built in).
        do_write(2'd3, 4'h0, 1'b0, 1'b0);
        do_write(2'd2, 4'h0, 1'b0, 1'b0);
        do_write(2'd1, 4'h4, 1'b0, 1'b0);
        do_write(2'd0, 4'h2, 1'b0, 1'b0);
        commit_pulse();
        idle(140);

        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
